// File: rtl/icache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_ctrl_pkg
// Shared CPU constants for the instruction cache:
//   - default geometry (index bits, RAM address width used for the tag)
//   - controller FSM state encoding
//   - word-alignment helper for fetch/refill addresses
// -----------------------------------------------------------------------------
package icache_ctrl_pkg;

  localparam int unsigned ICACHE_INDEX_BITS = 4;
  localparam int unsigned ICACHE_ADDR_WIDTH = 17;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

  // Clear the byte offset so the address names a whole 32-bit word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Tag/valid/data storage for a direct-mapped cache of one-word lines.
//   clk_i       clock; all writes on posedge
//   rst_ni      synchronous active-low reset; clears every valid bit only
//   rd_idx_i    combinational read port index
//   rd_valid_o  valid bit of the indexed line
//   rd_tag_o    tag of the indexed line
//   rd_data_o   data word of the indexed line
//   we_i        synchronous write enable (sets valid, writes tag and data)
//   wr_idx_i    write index
//   wr_tag_i    write tag
//   wr_data_i   write data word
// -----------------------------------------------------------------------------
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned TAG_BITS   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_BITS - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [31:0]           wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Only the valid bits need a defined reset value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped instruction cache controller with single-word refill.
//   clockIn    sole clock; all state updates on posedge
//   resetIn    synchronous active-low reset (overrides readyIn/clearIn)
//   readyIn    global enable; low freezes all state
//   clearIn    branch-mispredict flush; drops any pending request
//   fetchFlag  fetch request valid (held by requester until instOkOut)
//   fetchAddr  fetch byte address
//   instOkOut  one-cycle pulse: instruction valid
//   instOut    instruction word (holds last value otherwise)
//   memFlag    refill request to memory controller
//   memAddr    word-aligned refill address
//   memOk      one-cycle refill-done pulse from memory controller
//   memData    refill word, valid while memOk=1
// -----------------------------------------------------------------------------
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        fetchFlag,
  input  logic [31:0] fetchAddr,
  output logic        instOkOut,
  output logic [31:0] instOut,
  output logic        memFlag,
  output logic [31:0] memAddr,
  input  logic        memOk,
  input  logic [31:0] memData
);

  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  icache_state_e state_q;
  logic          inst_ok_q;
  logic [31:0]   inst_q;
  logic          mem_flag_q;
  logic [31:0]   mem_addr_q;

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [INDEX_BITS-1:0] refill_idx;
  logic [TAG_BITS-1:0]   refill_tag;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  accept;
  logic                  refill_we;
  logic [1:0]            unused_byte_offset;

  assign fetch_idx  = fetchAddr[INDEX_BITS+1:2];
  assign fetch_tag  = fetchAddr[ADDR_WIDTH-1:INDEX_BITS+2];
  // Refill writes use the latched address; fetchAddr is not re-sampled in REFILL.
  assign refill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign refill_tag = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

  assign unused_byte_offset = fetchAddr[1:0];

  assign hit    = rd_valid && (rd_tag == fetch_tag);
  // Suppressing acceptance while instOkOut is high stops the still-held
  // request from being served a second time in the response cycle.
  assign accept = fetchFlag && !inst_ok_q;

  // Array write is gated by the same conditions that let the FSM complete a
  // refill: reset, stall and flush all suppress it.
  assign refill_we = resetIn && readyIn && !clearIn && (state_q == REFILL) && memOk;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_i      (clockIn),
    .rst_ni     (resetIn),
    .rd_idx_i   (fetch_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (refill_we),
    .wr_idx_i   (refill_idx),
    .wr_tag_i   (refill_tag),
    .wr_data_i  (memData)
  );

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_q    <= IDLE;
      inst_ok_q  <= 1'b0;
      inst_q     <= '0;
      mem_flag_q <= 1'b0;
      mem_addr_q <= '0;
    end else if (readyIn) begin
      inst_ok_q <= 1'b0;
      if (clearIn) begin
        state_q    <= IDLE;
        mem_flag_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (hit) begin
                inst_ok_q <= 1'b1;
                inst_q    <= rd_data;
              end else begin
                mem_addr_q <= word_align(fetchAddr);
                mem_flag_q <= 1'b1;
                state_q    <= REFILL;
              end
            end
          end
          REFILL: begin
            if (memOk) begin
              inst_ok_q  <= 1'b1;
              inst_q     <= memData;
              mem_flag_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: begin
            state_q    <= IDLE;
            mem_flag_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign instOkOut = inst_ok_q;
  assign instOut   = inst_q;
  assign memFlag   = mem_flag_q;
  assign memAddr   = mem_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Scoreboard bench for icache_ctrl: the driver predicts each response from a
// line-level cache model and queues it; a negedge monitor pops and compares
// whenever instOkOut is presented.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        readyIn;
  logic        clearIn;
  logic        fetchFlag;
  logic [31:0] fetchAddr;
  logic        instOkOut;
  logic [31:0] instOut;
  logic        memFlag;
  logic [31:0] memAddr;
  logic        memOk;
  logic [31:0] memData;

  icache_ctrl #(
    .ADDR_WIDTH (17),
    .INDEX_BITS (4)
  ) dut (
    .clockIn   (clockIn),
    .resetIn   (resetIn),
    .readyIn   (readyIn),
    .clearIn   (clearIn),
    .fetchFlag (fetchFlag),
    .fetchAddr (fetchAddr),
    .instOkOut (instOkOut),
    .instOut   (instOut),
    .memFlag   (memFlag),
    .memAddr   (memAddr),
    .memOk     (memOk),
    .memData   (memData)
  );

  always #5 clockIn = ~clockIn;

  int unsigned cyc = 0;
  always @(posedge clockIn) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  // Reference cache: 16 lines, each remembers the 11-bit tag and word.
  bit          m_valid [16];
  logic [10:0] m_tag   [16];
  logic [31:0] m_word  [16];
  logic [31:0] last_inst;

  localparam int K_NORMAL  = 0;
  localparam int K_CLEAR   = 1;
  localparam int K_COLLIDE = 2;
  localparam int K_STALL   = 3;
  localparam int K_RESET   = 4;

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a >> 2) % 16;
  endfunction

  function automatic logic [10:0] tag_of(input logic [31:0] a);
    return 11'((a >> 6) & 32'h7FF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  // Monitor: every instOkOut pulse must match the oldest predicted response.
  always @(negedge clockIn) begin
    exp_t e;
    if (instOkOut === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instok: got instOkOut=1 instOut=%h expected no response (cycle %0d)",
                 instOut, cyc);
      end else begin
        e = sb.pop_front();
        chk("inst_data", instOut, e.data);
        chk("inst_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_reset(input logic mem_ok_during);
    resetIn   = 1'b0;
    readyIn   = 1'($urandom_range(0, 1));
    clearIn   = 1'($urandom_range(0, 1));
    fetchFlag = 1'b0;
    memOk     = mem_ok_during;
    memData   = $urandom;
    tick();
    resetIn = 1'b1;
    readyIn = 1'b1;
    clearIn = 1'b0;
    memOk   = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_inst = '0;
    sb.delete();
    chk("reset_instok", instOkOut, 32'd0);
    chk("reset_instout", instOut, 32'd0);
    chk("reset_memflag", memFlag, 32'd0);
    chk("reset_memaddr", memAddr, 32'd0);
  endtask

  task automatic finish_txn();
    tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL response_missing: got %0d pending responses expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
    chk("inst_hold", instOut, last_inst);
    chk("idle_memflag", memFlag, 32'd0);
  endtask

  // One complete request. `lat` is the cycle (after acceptance) in which the
  // memory raises memOk; `when` selects the refill cycle a disturbance hits.
  task automatic fetch(input logic [31:0] addr, input int unsigned lat, input int kind,
                       input int unsigned when, input logic [31:0] word);
    int unsigned li;
    bit          hit;
    li  = line_of(addr);
    hit = m_valid[li] && (m_tag[li] == tag_of(addr));
    fetchFlag = 1'b1;
    fetchAddr = addr;

    if (kind == K_CLEAR && when == 0) begin
      clearIn = 1'b1;
      tick();
      clearIn   = 1'b0;
      fetchFlag = 1'b0;
      chk("clear_accept_memflag", memFlag, 32'd0);
      finish_txn();
      return;
    end

    if (hit) begin
      sb.push_back('{data: m_word[li], due: cyc + 1});
      last_inst = m_word[li];
      tick();
      fetchFlag = 1'b0;
      chk("hit_memflag", memFlag, 32'd0);
      finish_txn();
      return;
    end

    tick();  // acceptance edge; refill request visible from here
    for (int unsigned i = 1; i <= lat; i++) begin
      chk("refill_memflag", memFlag, 32'd1);
      chk("refill_memaddr", memAddr, addr & 32'hFFFF_FFFC);
      if (kind == K_CLEAR && i == when) begin
        clearIn   = 1'b1;
        fetchFlag = 1'b0;
        tick();
        clearIn = 1'b0;
        chk("flush_memflag", memFlag, 32'd0);
        chk("flush_instok", instOkOut, 32'd0);
        finish_txn();
        return;
      end
      if (kind == K_RESET && i == when) begin
        do_reset(1'($urandom_range(0, 1)));
        finish_txn();
        return;
      end
      if (kind == K_STALL && i == when) begin
        readyIn = 1'b0;
        memData = ~word;
        for (int s = 0; s < 3; s++) begin
          memOk = (s == 1);
          tick();
          chk("stall_memflag", memFlag, 32'd1);
          chk("stall_memaddr", memAddr, addr & 32'hFFFF_FFFC);
        end
        memOk   = 1'b0;
        readyIn = 1'b1;
      end
      if (i < lat) tick();
    end

    memOk   = 1'b1;
    memData = word;
    if (kind == K_COLLIDE) begin
      clearIn   = 1'b1;
      fetchFlag = 1'b0;
      tick();
      clearIn = 1'b0;
      memOk   = 1'b0;
      chk("collide_memflag", memFlag, 32'd0);
    end else begin
      sb.push_back('{data: word, due: cyc + 1});
      tick();
      memOk     = 1'b0;
      fetchFlag = 1'b0;
      m_valid[li] = 1'b1;
      m_tag[li]   = tag_of(addr);
      m_word[li]  = word;
      last_inst   = word;
      chk("refill_done_memflag", memFlag, 32'd0);
    end
    finish_txn();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn   = 1'b1;
    readyIn   = 1'b1;
    clearIn   = 1'b0;
    fetchFlag = 1'b0;
    fetchAddr = '0;
    memOk     = 1'b0;
    memData   = '0;
    last_inst = '0;
    tick();
    do_reset(1'b0);

    // Cold miss, hit, conflict eviction.
    fetch(32'h0000_1004, 5, K_NORMAL, 0, 32'h00A0_0093);
    fetch(32'h0000_1004, 5, K_NORMAL, 0, 32'hDEAD_BEEF);
    fetch(32'h0000_1044, 3, K_NORMAL, 0, 32'h1111_2222);
    fetch(32'h0000_1004, 2, K_NORMAL, 0, 32'h00A0_0093);
    // Flush mid-refill, then the same address must miss.
    fetch(32'h0000_2000, 6, K_CLEAR, 3, 32'h3333_4444);
    fetch(32'h0000_2000, 2, K_NORMAL, 0, 32'h5555_6666);
    // Flush leaves cached lines intact.
    fetch(32'h0000_1004, 1, K_NORMAL, 0, 32'h0);
    // clearIn and memOk together.
    fetch(32'h0000_3008, 4, K_COLLIDE, 0, 32'h7777_8888);
    fetch(32'h0000_3008, 1, K_NORMAL, 0, 32'h9999_AAAA);
    // Stall with a memOk pulse while frozen; the later hit proves no write.
    fetch(32'h0000_400C, 4, K_STALL, 2, 32'hBBBB_CCCC);
    fetch(32'h0000_400C, 1, K_NORMAL, 0, 32'h0);
    // Reset in the middle of a refill wipes the cache.
    fetch(32'h0000_5010, 3, K_RESET, 2, 32'h1234_5678);
    fetch(32'h0000_1004, 2, K_NORMAL, 0, 32'hCAFE_F00D);

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      int unsigned lat;
      int unsigned r;
      int          kind;
      int unsigned when;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3)) | 32'h0000_8000;
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 17);
      lat = $urandom_range(1, 6);
      r   = $urandom_range(0, 19);
      if (r < 14) begin
        kind = K_NORMAL; when = 0;
      end else if (r < 16) begin
        kind = K_CLEAR;  when = $urandom_range(0, lat);
      end else if (r < 17) begin
        kind = K_COLLIDE; when = 0;
      end else if (r < 19) begin
        kind = K_STALL;  when = $urandom_range(1, lat);
      end else begin
        kind = K_RESET;  when = $urandom_range(1, lat);
      end
      fetch(a, lat, kind, when, $urandom);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 17, the number of RAM address bits used for the tag.
REQ-002 The block SHALL take parameter INDEX_BITS, default 4, giving 2^INDEX_BITS direct-mapped one-word lines.
REQ-003 The port list SHALL be, one per line:
- clockIn  in  1  sole clock; all state updates on posedge.
- resetIn  in  1  reset; synchronous, active-low.
- readyIn  in  1  global enable; low freezes all state.
- clearIn  in  1  branch-mispredict flush.
- fetchFlag  in  1  fetch request valid.
- fetchAddr  in  32  fetch byte address.
- instOkOut  out  1  one-cycle pulse; instruction valid.
- instOut  out  32  instruction word.
- memFlag  out  1  refill request to memory controller.
- memAddr  out  32  refill word address.
- memOk  in  1  one-cycle refill-done pulse from memory controller.
- memData  in  32  refill word, valid while memOk=1.

Function
REQ-004 Address split SHALL be: fetchAddr[1:0] ignored; index = fetchAddr[INDEX_BITS+1:2]; tag = fetchAddr[ADDR_WIDTH-1:INDEX_BITS+2].
REQ-005 Each line SHALL hold a valid bit, a tag and a 32-bit word.
REQ-006 The FSM SHALL have exactly two states, IDLE and REFILL.
REQ-007 In IDLE, a request SHALL be accepted on a posedge where fetchFlag=1 and instOkOut=0.
REQ-008 On an accepted hit (valid and tag match), the block SHALL drive instOkOut=1 and instOut=line word on the next cycle, and SHALL stay in IDLE.
REQ-009 On an accepted miss, the block SHALL latch the word-aligned address ({fetchAddr[31:2],2'b00}) and enter REFILL.
REQ-010 In REFILL, memFlag SHALL be 1 and memAddr SHALL equal the latched address, both held stable until memOk or clearIn.
REQ-011 In IDLE, memFlag SHALL be 0.
REQ-012 On memOk=1 in REFILL, the block SHALL:
- write memData, the tag and valid=1 into the indexed line;
- drive instOkOut=1 and instOut=memData on the next cycle;
- return to IDLE.
REQ-013 Miss-to-instOkOut latency SHALL be (memory latency + 1) cycles; hit latency SHALL be 1 cycle.
REQ-014 instOkOut SHALL be high for exactly one cycle per accepted request; instOut SHALL hold its last value otherwise.
REQ-015 The requester holds fetchFlag/fetchAddr stable until instOkOut; the block SHALL NOT re-sample fetchAddr while in REFILL.
REQ-016 clearIn=1 with readyIn=1 SHALL:
- force IDLE, memFlag=0, instOkOut=0 next cycle;
- discard any pending request.
REQ-017 clearIn SHALL take priority over memOk in the same cycle; that refill SHALL NOT write the array.
REQ-018 clearIn SHALL NOT modify valid bits; cached lines survive a flush.
REQ-019 readyIn=0 SHALL hold state, outputs, array and the latched address unchanged; memOk arriving while readyIn=0 SHALL be ignored.

Reset
REQ-020 resetIn=0 at a posedge SHALL force:
- state=IDLE;
- instOkOut=0, instOut=0, memFlag=0, memAddr=0;
- every valid bit = 0.
REQ-021 Reset SHALL override readyIn and clearIn; a refill in progress SHALL be abandoned without an array write.
REQ-022 Tag and data arrays SHALL NOT require reset.

Structure
REQ-023 FSM state encodings (IDLE, REFILL) and the default INDEX_BITS SHALL live in the shared CPU constants package.
REQ-024 The tag/valid/data storage SHALL be one sub-module, icache_array, with:
- a combinational read port;
- one synchronous write port;
- a synchronous valid-clear on reset.
REQ-025 The FSM and handshake logic SHALL remain in icache_ctrl.

Verification
REQ-026 Cold miss: reset, then fetchAddr=0x0000_1004, memory answers memOk after 5 cycles with memData=0x00A0_0093.
- memFlag=1 with memAddr=0x1004 throughout;
- instOkOut on cycle 6, instOut=0x00A0_0093.
REQ-027 Hit: repeat fetchAddr=0x1004 -> instOkOut next cycle, instOut=0x00A0_0093, memFlag stays 0.
REQ-028 Conflict: fetch 0x1004, then 0x1044 (same index, different tag) -> second fetch misses and refills; a re-fetch of 0x1004 misses again.
REQ-029 Flush mid-refill: miss on 0x2000, clearIn=1 on cycle 3.
- memFlag=0 and instOkOut=0 on cycle 4;
- a later fetch of 0x2000 misses.
REQ-030 Clear/memOk collision: clearIn and memOk high in the same cycle -> no instOkOut, and a later fetch of that address misses.
REQ-031 Stall: readyIn=0 for 3 cycles during REFILL with memOk pulsed -> memFlag/memAddr unchanged, no instOkOut, no array write.
